// File: rtl/k052591_loader.sv
// Host-side bus master for the 052591 PMC CPU port: program RAM loader,
// run/stop control and external work RAM reads over the BK path.
module k052591_loader #(
    parameter int STROBE_CYC = 2,
    parameter int STOP_GAP   = 4,
    parameter int HOLD_PC    = 1
) (
    input  logic        pin_M12,
    input  logic        pin_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic        prog_valid,
    output logic        prog_ready,
    input  logic [35:0] prog_word,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        pin_CS,
    output logic        pin_NRD,
    output logic        pin_BK,
    output logic        pin_START,
    output logic [12:0] pin_AB,
    output logic [7:0]  db_out,
    output logic        db_oe,
    input  logic [7:0]  db_in
);

    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam int GW = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
    localparam logic HOLD_BIT = (HOLD_PC != 0);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_PC_SU, S_PC_ST, S_PC_HD, S_FETCH,
        S_B_SU, S_B_ST, S_B_HD, S_RUN, S_GAP,
        S_R_SU, S_R_ST, S_R_HD
    } state_t;

    state_t        state, nx;
    logic [CW-1:0] st_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    byte_idx;
    logic [5:0]    words_left;
    logic [27:0]   word_q;
    logic          st_last;
    logic          in_st;

    assign in_st      = state inside {S_PC_ST, S_B_ST, S_R_ST};
    assign st_last    = (st_cnt == CW'(STROBE_CYC - 1));
    assign cmd_ready  = (state == S_IDLE) ||
                        (state == S_RUN && cmd_op == OP_STOP);
    assign prog_ready = (state == S_FETCH) && prog_valid;

    always_comb begin
        nx = state;
        case (state)
            S_IDLE: if (cmd_valid) begin
                case (cmd_op)
                    OP_LOAD:  nx = S_PC_SU;
                    OP_START: nx = S_RUN;
                    OP_READ:  nx = S_R_SU;
                    default:  nx = S_GAP;
                endcase
            end
            S_PC_SU: nx = S_PC_ST;
            S_PC_ST: if (st_last) nx = S_PC_HD;
            S_PC_HD: nx = S_FETCH;
            S_FETCH: if (prog_valid) nx = S_B_SU;
            S_B_SU:  nx = S_B_ST;
            S_B_ST:  if (st_last) nx = S_B_HD;
            S_B_HD: begin
                if (byte_idx != 3'd4)     nx = S_B_SU;
                else if (words_left == 0) nx = S_IDLE;
                else                      nx = S_FETCH;
            end
            S_RUN:   if (cmd_valid && cmd_op == OP_STOP) nx = S_GAP;
            S_GAP:   if (gap_cnt == '0) nx = S_IDLE;
            S_R_SU:  nx = S_R_ST;
            S_R_ST:  if (st_last) nx = S_R_HD;
            S_R_HD:  nx = S_IDLE;
            default: nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pin_M12 or posedge pin_RST) begin
        if (pin_RST) begin
            state      <= S_IDLE;
            st_cnt     <= '0;
            gap_cnt    <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            word_q     <= '0;
            pin_CS     <= 1'b1;
            pin_NRD    <= 1'b1;
            pin_BK     <= 1'b0;
            pin_START  <= 1'b0;
            pin_AB     <= '0;
            db_out     <= '0;
            db_oe      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= nx;
            pin_CS    <= !(nx inside {S_PC_ST, S_B_ST, S_R_ST});
            pin_NRD   <= !(nx inside {S_R_SU, S_R_ST, S_R_HD});
            pin_BK    <= nx inside {S_R_SU, S_R_ST, S_R_HD};
            db_oe     <= nx inside {S_PC_SU, S_PC_ST, S_PC_HD,
                                    S_B_SU, S_B_ST, S_B_HD};
            pin_START <= (nx == S_RUN);
            rd_valid  <= (nx == S_R_HD);
            busy      <= !(nx inside {S_IDLE, S_RUN});
            st_cnt    <= (in_st && !st_last) ? st_cnt + CW'(1) : '0;

            if (state == S_IDLE && cmd_valid) begin
                case (cmd_op)
                    OP_LOAD: begin
                        pin_AB     <= 13'h200;
                        db_out     <= {HOLD_BIT, 1'b0, cmd_addr[5:0]};
                        words_left <= cmd_len;
                    end
                    OP_READ: pin_AB  <= cmd_addr;
                    OP_STOP: gap_cnt <= GW'(STOP_GAP - 1);
                    default: ;
                endcase
            end
            if (state == S_RUN && cmd_valid && cmd_op == OP_STOP)
                gap_cnt <= GW'(STOP_GAP - 1);
            if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);

            // Bytes go out LSB first; the shifter keeps AB/db frozen through HD.
            if (state == S_FETCH && prog_valid) begin
                pin_AB   <= '0;
                db_out   <= prog_word[7:0];
                word_q   <= prog_word[35:8];
                byte_idx <= '0;
            end
            if (state == S_B_HD) begin
                if (byte_idx != 3'd4) begin
                    db_out   <= word_q[7:0];
                    word_q   <= word_q >> 8;
                    byte_idx <= byte_idx + 3'd1;
                end else if (words_left != 0) begin
                    words_left <= words_left - 6'd1;
                end
            end
            if (state == S_R_ST && st_last)
                rd_data <= db_in;
        end
    end

endmodule

// File: tb/tb_k052591_loader.sv
// Directed bench for k052591_loader: bus-cycle log per instance,
// table of single-word loads plus hand sequences for run/stop/read/reset.
module tb_k052591_loader;

    logic        clk = 0;
    logic        rst = 1;
    always #5 clk = ~clk;

    logic        cmd_valid = 0, cmd_valid1 = 0;
    logic [1:0]  cmd_op = 0;
    logic [12:0] cmd_addr = 0;
    logic [5:0]  cmd_len = 0;
    logic        prog_valid = 0;
    logic [35:0] prog_word = 0;
    logic [7:0]  db_in = 0;

    logic        rdy0, prdy0, rdv0, busy0, cs0, nrd0, bk0, st0, oe0;
    logic [7:0]  rdd0, db0;
    logic [12:0] ab0;
    logic        rdy1, prdy1, rdv1, busy1, cs1, nrd1, bk1, st1, oe1;
    logic [7:0]  rdd1, db1;
    logic [12:0] ab1;

    k052591_loader u0 (
        .pin_M12(clk), .pin_RST(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .prog_valid(prog_valid), .prog_ready(prdy0), .prog_word(prog_word),
        .rd_valid(rdv0), .rd_data(rdd0), .busy(busy0), .pin_CS(cs0),
        .pin_NRD(nrd0), .pin_BK(bk0), .pin_START(st0), .pin_AB(ab0),
        .db_out(db0), .db_oe(oe0), .db_in(db_in)
    );

    k052591_loader #(.STROBE_CYC(1), .STOP_GAP(4), .HOLD_PC(0)) u1 (
        .pin_M12(clk), .pin_RST(rst), .cmd_valid(cmd_valid1), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .prog_valid(1'b1), .prog_ready(prdy1), .prog_word(36'h9_8765_4321),
        .rd_valid(rdv1), .rd_data(rdd1), .busy(busy1), .pin_CS(cs1),
        .pin_NRD(nrd1), .pin_BK(bk1), .pin_START(st1), .pin_AB(ab1),
        .db_out(db1), .db_oe(oe1), .db_in(db_in)
    );

    typedef struct packed {
        logic [12:0] ab;
        logic [7:0]  db;
        logic        bk;
        logic        nrd;
        logic        oe;
        logic [3:0]  w;
        logic        stab;
    } bus_t;

    typedef struct packed {
        logic [5:0]      addr;
        logic [35:0]     word;
        logic [7:0]      pc;
        logic [4:0][7:0] b;
    } vec_t;

    bus_t        log0[$], log1[$];
    int          ts0[$], ts1[$];
    logic [7:0]  rdq[$];
    logic [35:0] progq[$];
    bit          gate_rand = 0;
    bit          pend = 0;
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    int          w0 = 0, w1 = 0;
    logic [12:0] lab0, lab1;
    logic [7:0]  ldb0, ldb1;

    // Bus monitor: one log entry per completed strobe, taken in HD.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            w0 = 0;
            w1 = 0;
        end else begin
            if (!cs0) begin
                w0++; lab0 = ab0; ldb0 = db0;
            end else if (w0 != 0) begin
                log0.push_back(bus_t'{ab0, db0, bk0, nrd0, oe0, w0[3:0],
                                      (ab0 == lab0) && (db0 == ldb0)});
                ts0.push_back(cyc);
                w0 = 0;
            end
            if (!cs1) begin
                w1++; lab1 = ab1; ldb1 = db1;
            end else if (w1 != 0) begin
                log1.push_back(bus_t'{ab1, db1, bk1, nrd1, oe1, w1[3:0],
                                      (ab1 == lab1) && (db1 == ldb1)});
                ts1.push_back(cyc);
                w1 = 0;
            end
            if (rdv0) rdq.push_back(rdd0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (pend) begin
            void'(progq.pop_front());
            pend = 0;
        end
        if (progq.size() > 0 && (!gate_rand || $urandom_range(0, 1) == 1)) begin
            prog_valid = 1;
            prog_word  = progq[0];
        end else begin
            prog_valid = 0;
        end
        #1;
        pend = prog_valid && prdy0;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic bus_t wr(input logic [12:0] a, input logic [7:0] d,
                                input logic [3:0] w);
        return bus_t'{a, d, 1'b0, 1'b1, 1'b1, w, 1'b1};
    endfunction

    function automatic logic [37:0] outs0();
        return {rdy0, prdy0, rdv0, rdd0, busy0, cs0, nrd0, bk0, st0, ab0, db0, oe0};
    endfunction

    localparam logic [37:0] RST_OUTS =
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 13'h0, 8'h00, 1'b0};

    task automatic send(input logic [1:0] op, input logic [12:0] a,
                        input logic [5:0] l);
        bit got = 0;
        cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1;
        for (int i = 0; i < 100; i++) begin
            if (rdy0) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_chk++;
            $display("FAIL accept_timeout: op %0d not accepted", op);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && busy0; i++) @(negedge clk);
        if (busy0) begin
            n_chk++;
            $display("FAIL idle_timeout: busy still %0d after %0d", busy0, budget);
        end
    endtask

    vec_t        vt[4];
    logic [35:0] words[64];
    logic [63:0] t64;
    logic [7:0]  eb;
    int          errs, n;

    initial begin
        vt[0] = '{6'd5,  36'h9_8765_4321, 8'h85, {8'h09, 8'h87, 8'h65, 8'h43, 8'h21}};
        vt[1] = '{6'd63, 36'hF_FFFF_FFFF, 8'hBF, {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vt[2] = '{6'd0,  36'h0_0000_0000, 8'h80, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vt[3] = '{6'd42, 36'hA_5A5A_C3C3, 8'hAA, {8'h0A, 8'h5A, 8'h5A, 8'hC3, 8'hC3}};

        repeat (3) @(negedge clk);
        chk("in_reset_outs", outs0(), RST_OUTS);
        rst = 0;
        @(negedge clk);
        chk("reset_outs", outs0(), RST_OUTS);
        chk("reset_u1_ready", rdy1, 1);

        // Short-strobe instance, PC not held
        cmd_op = 2'd0; cmd_addr = 13'd5; cmd_len = 0; cmd_valid1 = 1;
        for (int i = 0; i < 10 && !rdy1; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cmd_valid1 = 0;
        for (int i = 0; i < 100 && busy1; i++) @(negedge clk);
        chk("u1_n", log1.size(), 6);
        if (log1.size() == 6) begin
            chk("u1_pc", log1[0], wr(13'h200, 8'h05, 4'd1));
            chk("u1_b0", log1[1], wr(13'h0, 8'h21, 4'd1));
            chk("u1_b4", log1[5], wr(13'h0, 8'h09, 4'd1));
            chk("u1_gap_pc", ts1[1] - ts1[0], 4);
            chk("u1_period", ts1[5] - ts1[4], 3);
        end

        foreach (vt[v]) begin
            log0.delete(); ts0.delete();
            progq.push_back(vt[v].word);
            send(2'd0, {7'd0, vt[v].addr}, 6'd0);
            wait_idle(200);
            chk($sformatf("v%0d_n", v), log0.size(), 6);
            chk($sformatf("v%0d_prog", v), progq.size(), 0);
            if (log0.size() == 6) begin
                chk($sformatf("v%0d_pc", v), log0[0], wr(13'h200, vt[v].pc, 4'd2));
                for (int k = 0; k < 5; k++)
                    chk($sformatf("v%0d_b%0d", v, k), log0[k+1],
                        wr(13'h0, vt[v].b[k], 4'd2));
                chk($sformatf("v%0d_period", v), ts0[3] - ts0[2], 4);
            end
        end

        // 64 words with a starving source
        log0.delete(); ts0.delete();
        for (int i = 0; i < 64; i++) begin
            t64 = {$urandom, $urandom};
            words[i] = t64[35:0];
            progq.push_back(words[i]);
        end
        gate_rand = 1;
        send(2'd0, 13'd0, 6'd63);
        wait_idle(20000);
        gate_rand = 0;
        chk("bulk_n", log0.size(), 321);
        if (log0.size() == 321) begin
            chk("bulk_pc", log0[0], wr(13'h200, 8'h80, 4'd2));
            errs = 0;
            for (int i = 0; i < 320; i++) begin
                t64 = {28'd0, words[i/5]};
                eb = (i % 5 == 4) ? {4'd0, t64[35:32]} : t64[(i%5)*8 +: 8];
                if (log0[i+1] !== wr(13'h0, eb, 4'd2)) errs++;
            end
            chk("bulk_bytes_bad", errs, 0);
        end

        // READ
        log0.delete(); rdq.delete();
        db_in = 8'h5A;
        send(2'd2, 13'h1ABC, 6'd0);
        wait_idle(50);
        chk("rd_n", log0.size(), 1);
        if (log0.size() == 1) begin
            chk("rd_ab", log0[0].ab, 13'h1ABC);
            chk("rd_ctl", {log0[0].bk, log0[0].nrd, log0[0].oe, log0[0].w}, {3'b100, 4'd2});
        end
        chk("rd_pulses", rdq.size(), 1);
        if (rdq.size() == 1) chk("rd_data", rdq[0], 8'h5A);

        // STOP from IDLE: no bus, gap still observed
        log0.delete();
        send(2'd3, 13'd0, 6'd0);
        n = 0;
        while (busy0 && n < 20) begin n++; @(negedge clk); end
        chk("stop_idle_gap", n, 4);
        chk("stop_idle_bus", log0.size(), 0);

        // START, then READ held off until STOP
        send(2'd1, 13'd0, 6'd0);
        chk("run_start", st0, 1);
        chk("run_busy", busy0, 0);
        cmd_op = 2'd2; cmd_addr = 13'h0155; cmd_valid = 1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy0) errs++;
        end
        chk("run_holdoff", errs, 0);
        chk("run_no_bus", log0.size(), 0);
        cmd_op = 2'd3;
        #1;
        chk("run_stop_ready", rdy0, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("stop_start_low", st0, 0);
        n = 0;
        while (busy0 && n < 20) begin n++; @(negedge clk); end
        chk("stop_gap", n, 4);
        rdq.delete();
        db_in = 8'hC3;
        send(2'd2, 13'h0155, 6'd0);
        wait_idle(50);
        chk("post_rd_n", log0.size(), 1);
        if (log0.size() == 1) chk("post_rd_ab", log0[0].ab, 13'h0155);
        if (rdq.size() == 1) chk("post_rd_data", rdq[0], 8'hC3);
        else chk("post_rd_pulses", rdq.size(), 1);

        // Reset during the third byte strobe
        log0.delete(); ts0.delete();
        progq.push_back(36'h1_2345_6789);
        send(2'd0, 13'd9, 6'd0);
        for (int i = 0; i < 200 && log0.size() < 3; i++) @(negedge clk);
        for (int i = 0; i < 20 && cs0; i++) @(negedge clk);
        chk("mid_cs_low", cs0, 0);
        rst = 1;
        #1;
        chk("mid_reset_outs", outs0(), RST_OUTS);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        log0.delete(); ts0.delete();
        progq.push_back(36'h9_8765_4321);
        send(2'd0, 13'd7, 6'd0);
        wait_idle(200);
        chk("resync_n", log0.size(), 6);
        if (log0.size() == 6) begin
            chk("resync_pc", log0[0], wr(13'h200, 8'h87, 4'd2));
            chk("resync_b4", log0[5], wr(13'h0, 8'h09, 4'd2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
